// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcodes, ALU control encodings and sequencer states.
package alu_seq_pkg;

   // Native opcode width of the decode map.
   localparam int unsigned OPC_BITS  = 5;
   // Native width of the ALU control encodings below.
   localparam int unsigned CTRL_BITS = 4;

   typedef enum logic [OPC_BITS-1:0] {
      OP_J       = 5'b00000,
      OP_JAL     = 5'b00111,
      OP_ADD     = 5'b01000,
      OP_SUB     = 5'b01001,
      OP_SL      = 5'b01010,
      OP_SR      = 5'b01011,
      OP_AND     = 5'b01100,
      OP_OR      = 5'b01101,
      OP_XOR     = 5'b01110,
      OP_NOR     = 5'b01111,
      OP_NAND    = 5'b10000,
      OP_NOR_ALT = 5'b10001,
      OP_JR      = 5'b10010,
      OP_SLT     = 5'b10011,
      OP_SGT     = 5'b10100,
      OP_ADDI    = 5'b11000,
      OP_SUBI    = 5'b11001,
      OP_LW      = 5'b11010,
      OP_SW      = 5'b11011,
      OP_BEQ     = 5'b11100,
      OP_BNE     = 5'b11101
   } opcode_e;

   localparam logic [CTRL_BITS-1:0] CTRL_ADD     = 4'b0000;
   localparam logic [CTRL_BITS-1:0] CTRL_SUB     = 4'b0001;
   localparam logic [CTRL_BITS-1:0] CTRL_SL      = 4'b0010;
   localparam logic [CTRL_BITS-1:0] CTRL_SR      = 4'b0011;
   localparam logic [CTRL_BITS-1:0] CTRL_AND     = 4'b0100;
   localparam logic [CTRL_BITS-1:0] CTRL_OR      = 4'b0101;
   localparam logic [CTRL_BITS-1:0] CTRL_XOR     = 4'b0110;
   localparam logic [CTRL_BITS-1:0] CTRL_NOR     = 4'b0111;
   localparam logic [CTRL_BITS-1:0] CTRL_NAND    = 4'b1000;
   localparam logic [CTRL_BITS-1:0] CTRL_NOR_ALT = 4'b1001;
   localparam logic [CTRL_BITS-1:0] CTRL_JR      = 4'b1010;
   localparam logic [CTRL_BITS-1:0] CTRL_SLT     = 4'b1011;
   localparam logic [CTRL_BITS-1:0] CTRL_SGT     = 4'b1100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      SHIFT = 2'd2
   } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode -> {ALU control, shift flag, legal flag}.
module alu_op_decode
   import alu_seq_pkg::*;
#(
   parameter int unsigned OP_W = 5
) (
   input  logic [OP_W-1:0]      op,
   output logic [CTRL_BITS-1:0] ctrl,
   output logic                 is_shift,
   output logic                 legal
);

   // Widen to at least the native opcode width so narrower/wider OP_W both work.
   localparam int unsigned EXT_W = (OP_W > OPC_BITS) ? OP_W : OPC_BITS;

   logic [EXT_W-1:0]    op_ext;
   logic [OPC_BITS-1:0] op_lo;
   logic                hi_zero;
   logic [CTRL_BITS-1:0] map_ctrl;
   logic                 map_legal;
   logic                 map_shift;

   assign op_ext  = EXT_W'(op);
   assign op_lo   = op_ext[OPC_BITS-1:0];
   // Any set bit above the native field makes the opcode illegal.
   assign hi_zero = ((op_ext >> OPC_BITS) == '0);

   // Opcode table lookup; unknown codes decode to ADD with legal cleared.
   always_comb begin
      map_ctrl  = CTRL_ADD;
      map_legal = 1'b1;
      map_shift = 1'b0;
      case (op_lo)
         OP_ADD:     map_ctrl = CTRL_ADD;
         OP_SUB:     map_ctrl = CTRL_SUB;
         OP_SL: begin
            map_ctrl  = CTRL_SL;
            map_shift = 1'b1;
         end
         OP_SR: begin
            map_ctrl  = CTRL_SR;
            map_shift = 1'b1;
         end
         OP_AND:     map_ctrl = CTRL_AND;
         OP_OR:      map_ctrl = CTRL_OR;
         OP_XOR:     map_ctrl = CTRL_XOR;
         OP_NOR:     map_ctrl = CTRL_NOR;
         OP_NAND:    map_ctrl = CTRL_NAND;
         OP_NOR_ALT: map_ctrl = CTRL_NOR_ALT;
         OP_JR:      map_ctrl = CTRL_JR;
         OP_SLT:     map_ctrl = CTRL_SLT;
         OP_SGT:     map_ctrl = CTRL_SGT;
         // Address/jump ops reuse the adder.
         OP_ADDI, OP_LW, OP_SW, OP_J, OP_JAL: map_ctrl = CTRL_ADD;
         // Compare-style ops reuse the subtractor.
         OP_SUBI, OP_BEQ, OP_BNE:              map_ctrl = CTRL_SUB;
         default: begin
            map_ctrl  = CTRL_ADD;
            map_legal = 1'b0;
         end
      endcase
   end

   // Gate the table result with the upper-bit check.
   always_comb begin
      legal    = map_legal & hi_zero;
      is_shift = map_shift & hi_zero;
      ctrl     = legal ? map_ctrl : CTRL_ADD;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU op sequencer: accepts opcodes on a valid/ready handshake and
// issues ALU control beats, expanding shifts into single-bit beats.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned OP_W      = 5,
   parameter int unsigned CTRL_W    = 4,
   parameter int unsigned SHAMT_W   = 5,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OP_W-1:0]      in_op,
   input  logic [SHAMT_W-1:0]   in_shamt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CTRL_W-1:0]    out_ctrl,
   output logic                 out_last,
   output logic                 out_bypass,
   output logic                 err_illegal,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count,
   input  logic                 err_clr
);

   state_e               state;
   logic [SHAMT_W-1:0]   beat_cnt;
   logic [CTRL_BITS-1:0] dec_ctrl;
   logic                 dec_is_shift;
   logic                 dec_legal;
   logic                 accept;
   logic                 beat_done;
   logic                 last_done;
   logic                 shift_nz;

   alu_op_decode #(
      .OP_W (OP_W)
   ) u_decode (
      .op       (in_op),
      .ctrl     (dec_ctrl),
      .is_shift (dec_is_shift),
      .legal    (dec_legal)
   );

   // Handshake qualifiers; the final-beat term lets a new op follow with no bubble.
   always_comb begin
      beat_done = out_valid & out_ready;
      last_done = beat_done & out_last;
      in_ready  = (state == IDLE) | last_done;
      accept    = in_valid & in_ready;
      shift_nz  = dec_is_shift & (in_shamt != '0);
   end

   // FSM, beat counter and registered beat outputs; a new acceptance overrides
   // the retirement of the previous op in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         beat_cnt    <= '0;
         out_valid   <= 1'b0;
         out_ctrl    <= '0;
         out_last    <= 1'b0;
         out_bypass  <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         err_illegal <= 1'b0;

         case (state)
            IDLE: begin
               out_valid <= 1'b0;
            end
            ISSUE: begin
               if (beat_done) begin
                  state      <= IDLE;
                  out_valid  <= 1'b0;
                  out_last   <= 1'b0;
                  out_bypass <= 1'b0;
               end
            end
            SHIFT: begin
               if (beat_done) begin
                  beat_cnt <= beat_cnt - SHAMT_W'(1);
                  if (beat_cnt == SHAMT_W'(1)) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end else begin
                     out_last <= (beat_cnt == SHAMT_W'(2));
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         endcase

         if (accept) begin
            if (dec_legal) begin
               out_valid <= 1'b1;
               out_ctrl  <= CTRL_W'(dec_ctrl);
               if (shift_nz) begin
                  state      <= SHIFT;
                  beat_cnt   <= in_shamt;
                  out_last   <= (in_shamt == SHAMT_W'(1));
                  out_bypass <= 1'b0;
               end else begin
                  // Shift by zero still emits one beat so the operand flows through.
                  state      <= ISSUE;
                  beat_cnt   <= '0;
                  out_last   <= 1'b1;
                  out_bypass <= dec_is_shift;
               end
            end else begin
               // Illegal op is consumed without a beat.
               state       <= IDLE;
               out_valid   <= 1'b0;
               out_last    <= 1'b0;
               out_bypass  <= 1'b0;
               err_illegal <= 1'b1;
            end
         end
      end
   end

   // Sticky flag and saturating counter; a same-cycle illegal beats err_clr.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else if (accept && !dec_legal) begin
         err_sticky <= 1'b1;
         if (err_clr) begin
            err_count <= ERR_CNT_W'(1);
         end else if (err_count != '1) begin
            err_count <= err_count + ERR_CNT_W'(1);
         end
      end else if (err_clr) begin
         err_sticky <= 1'b0;
         err_count  <= '0;
      end
   end

endmodule
